// File: rtl/primitive_assembly_ctrl.sv
// ---------------------------------------------------------------------------
// primitive_assembly_ctrl
//
// Turns the command stream retired by writeback into complete point, line or
// triangle primitives for the GPU stage. It tracks BEGIN/END framing, the
// current color and the number of vertices collected. A finished primitive is
// presented with its vertices and GSR word under a valid/stall handshake. One
// extra finished primitive can wait in the assembly slots (FULL state). While
// it waits, writeback is stalled.
//
// Ports
//   I_CLOCK           clock, all state updates on the rising edge
//   I_RESET_N         asynchronous active-low reset
//   I_Valid           command valid from writeback
//   I_Cmd             000 NOP, 001 BEGIN, 010 VERTEX, 011 COLOR, 100 END
//   I_PrimType        with BEGIN: 01 point, 10 line, 11 triangle
//   I_VertexData      vertex word carried by VERTEX
//   I_ColorData       color value carried by COLOR
//   I_GPUStallSignal  GPU stage cannot accept this cycle
//   O_Stall           command not accepted this cycle (combinational)
//   O_PrimValid       output primitive valid
//   O_VertexV1..V3    output vertices, unused slots forced to zero
//   O_GSRValue        {prim_type, color} captured at completion
//   O_PrimCount       primitives handed to the GPU, wraps
//   O_Error           one-cycle pulse after a protocol violation
// ---------------------------------------------------------------------------
module primitive_assembly_ctrl #(
   parameter int VERTEX_W = 30,
   parameter int COLOR_W  = 6,
   parameter int CNT_W    = 16
) (
   input  logic                  I_CLOCK,
   input  logic                  I_RESET_N,
   input  logic                  I_Valid,
   input  logic [2:0]            I_Cmd,
   input  logic [1:0]            I_PrimType,
   input  logic [VERTEX_W-1:0]   I_VertexData,
   input  logic [COLOR_W-1:0]    I_ColorData,
   input  logic                  I_GPUStallSignal,
   output logic                  O_Stall,
   output logic                  O_PrimValid,
   output logic [VERTEX_W-1:0]   O_VertexV1,
   output logic [VERTEX_W-1:0]   O_VertexV2,
   output logic [VERTEX_W-1:0]   O_VertexV3,
   output logic [COLOR_W+1:0]    O_GSRValue,
   output logic [CNT_W-1:0]      O_PrimCount,
   output logic                  O_Error
);

   localparam logic [2:0] CMD_BEGIN  = 3'b001;
   localparam logic [2:0] CMD_VERTEX = 3'b010;
   localparam logic [2:0] CMD_COLOR  = 3'b011;
   localparam logic [2:0] CMD_END    = 3'b100;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FULL    = 2'd2
   } state_t;

   state_t                state;
   logic [1:0]            prim_type;
   logic [COLOR_W-1:0]    color;
   logic [1:0]            vcnt;
   logic [VERTEX_W-1:0]   slot_v1;
   logic [VERTEX_W-1:0]   slot_v2;
   logic [VERTEX_W-1:0]   slot_v3;

   logic                  accept;
   logic                  drain;
   logic [1:0]            vcnt_inc;
   logic                  completing;
   logic                  load_direct;
   logic [VERTEX_W-1:0]   done_v1;
   logic [VERTEX_W-1:0]   done_v2;
   logic [VERTEX_W-1:0]   done_v3;

   // Slot idx (1..3) is used only when the primitive has at least idx
   // vertices; the type encoding equals the vertex count.
   function automatic logic [VERTEX_W-1:0] mask_slot(
      input logic [1:0]          ptype,
      input logic [1:0]          idx,
      input logic [VERTEX_W-1:0] v
   );
      return (ptype >= idx) ? v : '0;
   endfunction

   assign O_Stall  = (state == FULL);
   assign accept   = I_Valid && !O_Stall;
   assign drain    = O_PrimValid && !I_GPUStallSignal;
   assign vcnt_inc = vcnt + 2'd1;

   always_comb begin
      completing  = 1'b0;
      load_direct = 1'b0;
      if (accept && (state == COLLECT) && (I_Cmd == CMD_VERTEX) &&
          (vcnt_inc == prim_type)) begin
         completing = 1'b1;
      end
      // The output register is free now if empty or being drained this edge.
      if (completing && (!O_PrimValid || drain)) begin
         load_direct = 1'b1;
      end
      // Merge the arriving vertex into the slot it belongs to; stale slot
      // contents from an earlier primitive are masked off by type.
      done_v1 = mask_slot(prim_type, 2'd1, (vcnt == 2'd0) ? I_VertexData : slot_v1);
      done_v2 = mask_slot(prim_type, 2'd2, (vcnt == 2'd1) ? I_VertexData : slot_v2);
      done_v3 = mask_slot(prim_type, 2'd3, (vcnt == 2'd2) ? I_VertexData : slot_v3);
   end

   always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         state       <= IDLE;
         prim_type   <= '0;
         color       <= '0;
         vcnt        <= '0;
         slot_v1     <= '0;
         slot_v2     <= '0;
         slot_v3     <= '0;
         O_PrimValid <= 1'b0;
         O_VertexV1  <= '0;
         O_VertexV2  <= '0;
         O_VertexV3  <= '0;
         O_GSRValue  <= '0;
         O_PrimCount <= '0;
         O_Error     <= 1'b0;
      end else begin
         O_Error <= 1'b0;

         // A drain lowers valid; a reload later in this block overrides it.
         if (drain) begin
            O_PrimValid <= 1'b0;
            O_PrimCount <= O_PrimCount + 1'b1;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  case (I_Cmd)
                     CMD_BEGIN: begin
                        if (I_PrimType != 2'b00) begin
                           prim_type <= I_PrimType;
                           vcnt      <= '0;
                           state     <= COLLECT;
                        end else begin
                           O_Error <= 1'b1;
                        end
                     end
                     CMD_VERTEX, CMD_END: O_Error <= 1'b1;
                     CMD_COLOR:           color   <= I_ColorData;
                     default: ;
                  endcase
               end
            end

            COLLECT: begin
               if (accept) begin
                  case (I_Cmd)
                     CMD_VERTEX: begin
                        if (completing) begin
                           vcnt <= '0;
                           if (load_direct) begin
                              O_VertexV1  <= done_v1;
                              O_VertexV2  <= done_v2;
                              O_VertexV3  <= done_v3;
                              O_GSRValue  <= {prim_type, color};
                              O_PrimValid <= 1'b1;
                           end else begin
                              // Park the finished primitive until the output
                              // register frees up.
                              slot_v1 <= done_v1;
                              slot_v2 <= done_v2;
                              slot_v3 <= done_v3;
                              state   <= FULL;
                           end
                        end else begin
                           case (vcnt)
                              2'd0:    slot_v1 <= I_VertexData;
                              2'd1:    slot_v2 <= I_VertexData;
                              default: slot_v3 <= I_VertexData;
                           endcase
                           vcnt <= vcnt_inc;
                        end
                     end
                     CMD_COLOR: color <= I_ColorData;
                     CMD_END: begin
                        if (vcnt != 2'd0) begin
                           O_Error <= 1'b1;
                        end
                        vcnt  <= '0;
                        state <= IDLE;
                     end
                     CMD_BEGIN: begin
                        O_Error <= 1'b1;
                        vcnt    <= '0;
                        if (I_PrimType != 2'b00) begin
                           prim_type <= I_PrimType;
                        end else begin
                           state <= IDLE;
                        end
                     end
                     default: ;
                  endcase
               end
            end

            FULL: begin
               // Type and color cannot change while stalled, so the GSR built
               // here matches the values at completion.
               if (drain) begin
                  O_VertexV1  <= slot_v1;
                  O_VertexV2  <= slot_v2;
                  O_VertexV3  <= slot_v3;
                  O_GSRValue  <= {prim_type, color};
                  O_PrimValid <= 1'b1;
                  vcnt        <= '0;
                  state       <= COLLECT;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_primitive_assembly_ctrl.sv
module tb_primitive_assembly_ctrl;

   localparam int VW = 30;
   localparam int CW = 6;
   localparam int NW = 16;

   localparam logic [2:0] C_NOP    = 3'b000;
   localparam logic [2:0] C_BEGIN  = 3'b001;
   localparam logic [2:0] C_VERTEX = 3'b010;
   localparam logic [2:0] C_COLOR  = 3'b011;
   localparam logic [2:0] C_END    = 3'b100;

   logic           clk;
   logic           rst_n;
   logic           valid;
   logic [2:0]     cmd;
   logic [1:0]     ptype;
   logic [VW-1:0]  vdata;
   logic [CW-1:0]  cdata;
   logic           gpu_stall;
   logic           stall;
   logic           prim_valid;
   logic [VW-1:0]  v1, v2, v3;
   logic [CW+1:0]  gsr;
   logic [NW-1:0]  count;
   logic           err;

   int tests = 0;
   int fails = 0;

   primitive_assembly_ctrl #(.VERTEX_W(VW), .COLOR_W(CW), .CNT_W(NW)) dut (
      .I_CLOCK(clk), .I_RESET_N(rst_n), .I_Valid(valid), .I_Cmd(cmd),
      .I_PrimType(ptype), .I_VertexData(vdata), .I_ColorData(cdata),
      .I_GPUStallSignal(gpu_stall), .O_Stall(stall), .O_PrimValid(prim_valid),
      .O_VertexV1(v1), .O_VertexV2(v2), .O_VertexV3(v3), .O_GSRValue(gsr),
      .O_PrimCount(count), .O_Error(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Present one command for one clock edge; returns 1 ns after that edge.
   task automatic do_cmd(input logic [2:0] c, input logic [1:0] t,
                         input logic [VW-1:0] v, input logic [CW-1:0] col);
      @(negedge clk);
      valid = 1'b1; cmd = c; ptype = t; vdata = v; cdata = col;
      @(posedge clk);
      #1;
      valid = 1'b0; cmd = C_NOP;
   endtask

   task automatic test_reset();
      #1;
      tests++; if (prim_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0h want 0", prim_valid); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %0h want 0", stall); end
      tests++; if ({v1, v2, v3} !== '0) begin fails++; $display("FAIL rst_vertices got %0h want 0", {v1, v2, v3}); end
      tests++; if (gsr !== '0 || count !== '0 || err !== 1'b0) begin fails++; $display("FAIL rst_misc got gsr=%0h cnt=%0h err=%0h want 0", gsr, count, err); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_triangle();
      do_cmd(C_BEGIN, 2'b11, '0, '0);
      do_cmd(C_COLOR, 2'b00, '0, 6'h2A);
      do_cmd(C_VERTEX, 2'b00, 30'h0000_0A01, '0);
      do_cmd(C_VERTEX, 2'b00, 30'h0000_0B02, '0);
      tests++; if (prim_valid !== 1'b0) begin fails++; $display("FAIL tri_early_valid got %0h want 0", prim_valid); end
      do_cmd(C_VERTEX, 2'b00, 30'h0000_0C03, '0);
      tests++; if (prim_valid !== 1'b1) begin fails++; $display("FAIL tri_valid got %0h want 1", prim_valid); end
      tests++; if (v1 !== 30'h0A01 || v2 !== 30'h0B02 || v3 !== 30'h0C03) begin fails++; $display("FAIL tri_vertices got %0h %0h %0h want a01 b02 c03", v1, v2, v3); end
      tests++; if (gsr !== 8'hEA) begin fails++; $display("FAIL tri_gsr got %0h want ea", gsr); end
      tests++; if (count !== 16'd0) begin fails++; $display("FAIL tri_count_pre got %0d want 0", count); end
      @(posedge clk); #1;
      tests++; if (prim_valid !== 1'b0 || count !== 16'd1) begin fails++; $display("FAIL tri_drain got v=%0h cnt=%0d want 0 1", prim_valid, count); end
      do_cmd(C_END, 2'b00, '0, '0);
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL tri_end_err got %0h want 0", err); end
   endtask

   task automatic test_line_list_stall();
      gpu_stall = 1'b1;
      do_cmd(C_BEGIN, 2'b10, '0, '0);
      do_cmd(C_VERTEX, 2'b00, 30'h0111_1111, '0);
      do_cmd(C_VERTEX, 2'b00, 30'h0222_2222, '0);
      tests++; if (prim_valid !== 1'b1 || v1 !== 30'h0111_1111 || v2 !== 30'h0222_2222 || v3 !== '0) begin fails++; $display("FAIL line1 got v=%0h %0h %0h %0h want 1 1111111 2222222 0", prim_valid, v1, v2, v3); end
      do_cmd(C_VERTEX, 2'b00, 30'h0333_3333, '0);
      do_cmd(C_VERTEX, 2'b00, 30'h0444_4444, '0);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL line_full_stall got %0h want 1", stall); end
      tests++; if (v1 !== 30'h0111_1111 || count !== 16'd1) begin fails++; $display("FAIL line_held got v1=%0h cnt=%0d want 1111111 1", v1, count); end
      @(negedge clk); gpu_stall = 1'b0;
      @(posedge clk); #1;
      tests++; if (prim_valid !== 1'b1 || v1 !== 30'h0333_3333 || v2 !== 30'h0444_4444 || v3 !== '0) begin fails++; $display("FAIL line2 got v=%0h %0h %0h %0h want 1 3333333 4444444 0", prim_valid, v1, v2, v3); end
      tests++; if (count !== 16'd2 || stall !== 1'b0) begin fails++; $display("FAIL line2_cnt got cnt=%0d stall=%0h want 2 0", count, stall); end
      tests++; if (gsr !== 8'hAA) begin fails++; $display("FAIL line_gsr got %0h want aa", gsr); end
      @(posedge clk); #1;
      tests++; if (prim_valid !== 1'b0 || count !== 16'd3) begin fails++; $display("FAIL line_drain got v=%0h cnt=%0d want 0 3", prim_valid, count); end
      do_cmd(C_END, 2'b00, '0, '0);
   endtask

   task automatic test_point();
      do_cmd(C_BEGIN, 2'b01, '0, '0);
      do_cmd(C_VERTEX, 2'b00, 30'h1555_0007, '0);
      tests++; if (prim_valid !== 1'b1 || v1 !== 30'h1555_0007) begin fails++; $display("FAIL pt_v1 got v=%0h v1=%0h want 1 15550007", prim_valid, v1); end
      tests++; if (v2 !== '0 || v3 !== '0) begin fails++; $display("FAIL pt_unused got %0h %0h want 0 0", v2, v3); end
      tests++; if (gsr !== 8'h6A || err !== 1'b0) begin fails++; $display("FAIL pt_gsr got gsr=%0h err=%0h want 6a 0", gsr, err); end
      do_cmd(C_END, 2'b00, '0, '0);
      tests++; if (err !== 1'b0 || prim_valid !== 1'b0 || count !== 16'd4) begin fails++; $display("FAIL pt_end got err=%0h v=%0h cnt=%0d want 0 0 4", err, prim_valid, count); end
   endtask

   task automatic test_errors();
      do_cmd(C_COLOR, 2'b00, '0, 6'h05);
      do_cmd(C_BEGIN, 2'b11, '0, '0);
      do_cmd(C_VERTEX, 2'b00, 30'h0000_00AA, '0);
      do_cmd(C_END, 2'b00, '0, '0);
      tests++; if (err !== 1'b1 || prim_valid !== 1'b0) begin fails++; $display("FAIL err_partial_end got err=%0h v=%0h want 1 0", err, prim_valid); end
      @(posedge clk); #1;
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_pulse_width got %0h want 0", err); end
      do_cmd(C_VERTEX, 2'b00, 30'h0000_00BB, '0);
      tests++; if (err !== 1'b1 || prim_valid !== 1'b0) begin fails++; $display("FAIL err_idle_vertex got err=%0h v=%0h want 1 0", err, prim_valid); end
      do_cmd(C_BEGIN, 2'b00, '0, '0);
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_begin_type0 got %0h want 1", err); end
      do_cmd(C_BEGIN, 2'b11, '0, '0);
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_begin_ok got %0h want 0", err); end
      do_cmd(C_VERTEX, 2'b00, 30'h0000_00CC, '0);
      do_cmd(C_BEGIN, 2'b01, '0, '0);
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_begin_restart got %0h want 1", err); end
      do_cmd(C_VERTEX, 2'b00, 30'h0000_00DD, '0);
      tests++; if (prim_valid !== 1'b1 || v1 !== 30'hDD || v2 !== '0 || gsr !== 8'h45) begin fails++; $display("FAIL err_restart_prim got v=%0h v1=%0h v2=%0h gsr=%0h want 1 dd 0 45", prim_valid, v1, v2, gsr); end
      do_cmd(C_END, 2'b00, '0, '0);
      tests++; if (count !== 16'd5 || err !== 1'b0) begin fails++; $display("FAIL err_final got cnt=%0d err=%0h want 5 0", count, err); end
   endtask

   task automatic test_reset_mid_full();
      gpu_stall = 1'b1;
      do_cmd(C_BEGIN, 2'b01, '0, '0);
      do_cmd(C_VERTEX, 2'b00, 30'h0000_1001, '0);
      do_cmd(C_VERTEX, 2'b00, 30'h0000_1002, '0);
      tests++; if (stall !== 1'b1 || prim_valid !== 1'b1) begin fails++; $display("FAIL rmf_full got stall=%0h v=%0h want 1 1", stall, prim_valid); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (prim_valid !== 1'b0 || stall !== 1'b0 || count !== '0) begin fails++; $display("FAIL rmf_async got v=%0h stall=%0h cnt=%0d want 0 0 0", prim_valid, stall, count); end
      tests++; if ({v1, v2, v3} !== '0 || gsr !== '0) begin fails++; $display("FAIL rmf_clear got vtx=%0h gsr=%0h want 0 0", {v1, v2, v3}, gsr); end
      gpu_stall = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      do_cmd(C_BEGIN, 2'b11, '0, '0);
      do_cmd(C_VERTEX, 2'b00, 30'h0000_2001, '0);
      do_cmd(C_VERTEX, 2'b00, 30'h0000_2002, '0);
      do_cmd(C_VERTEX, 2'b00, 30'h0000_2003, '0);
      tests++; if (prim_valid !== 1'b1 || v3 !== 30'h2003 || gsr !== 8'hC0) begin fails++; $display("FAIL rmf_after got v=%0h v3=%0h gsr=%0h want 1 2003 c0", prim_valid, v3, gsr); end
      @(posedge clk); #1;
      tests++; if (count !== 16'd1) begin fails++; $display("FAIL rmf_count got %0d want 1", count); end
   endtask

   task automatic test_count_wrap();
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      do_cmd(C_BEGIN, 2'b01, '0, '0);
      // Streaming points: first edge loads, every later edge drains and reloads.
      @(negedge clk);
      valid = 1'b1; cmd = C_VERTEX; vdata = 30'h0000_0123;
      repeat (65536) @(posedge clk);
      #1;
      valid = 1'b0; cmd = C_NOP;
      tests++; if (count !== 16'hFFFF || prim_valid !== 1'b1) begin fails++; $display("FAIL wrap_pre got cnt=%0h v=%0h want ffff 1", count, prim_valid); end
      @(posedge clk); #1;
      tests++; if (count !== 16'h0000 || prim_valid !== 1'b0) begin fails++; $display("FAIL wrap_post got cnt=%0h v=%0h want 0 0", count, prim_valid); end
   endtask

   initial begin
      rst_n = 1'b0; valid = 1'b0; cmd = C_NOP; ptype = 2'b00;
      vdata = '0; cdata = '0; gpu_stall = 1'b0;
      test_reset();
      test_triangle();
      test_line_list_stall();
      test_point();
      test_errors();
      test_reset_mid_full();
      test_count_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
